// File: rtl/if_id_assembler_pkg.sv
// rtl/if_id_assembler_pkg.sv - shared fetch/decode constants and IF/ID state encoding
package if_id_assembler_pkg;

  localparam int PC_W         = 32;
  localparam int WORD_W       = 16;
  localparam int IMM_FLAG_BIT = 0;

  localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

  // S_IMM means an opcode word is parked in hold_op waiting for its immediate
  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } asmState_t;

endpackage

// File: rtl/if_id_assembler_imm_flag_decode.sv
// rtl/if_id_assembler_imm_flag_decode.sv - flags an opcode word whose next word is its immediate
module imm_flag_decode
  import if_id_assembler_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic              hasImm
);

  localparam logic [WORD_W-1:0] FLAG_MASK = WORD_W'(1) << IMM_FLAG_BIT;

  assign hasImm = |(word & FLAG_MASK);

endmodule

// File: rtl/if_id_assembler.sv
// rtl/if_id_assembler.sv - pairs opcode/immediate fetch words into the IF/ID pipeline register
module if_id_assembler
  import if_id_assembler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              stall,
  input  logic              flush,
  output logic              fetch_hold,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_imm,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_has_imm
);

  asmState_t         state, stateNext;
  logic [WORD_W-1:0] holdOp, holdOpNext;
  logic [PC_W-1:0]   holdPc, holdPcNext;
  logic              validNext, hasImmNext;
  logic [WORD_W-1:0] instrNext, immNext;
  logic [PC_W-1:0]   pcNext;
  logic              wordHasImm;

  imm_flag_decode flagDecode (
    .word   (in_word),
    .hasImm (wordHasImm)
  );

  assign fetch_hold = stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_OP;
      holdOp      <= NOP_WORD;
      holdPc      <= '0;
      out_valid   <= 1'b0;
      out_instr   <= NOP_WORD;
      out_imm     <= NOP_WORD;
      out_pc      <= '0;
      out_has_imm <= 1'b0;
    end else begin
      state       <= stateNext;
      holdOp      <= holdOpNext;
      holdPc      <= holdPcNext;
      out_valid   <= validNext;
      out_instr   <= instrNext;
      out_imm     <= immNext;
      out_pc      <= pcNext;
      out_has_imm <= hasImmNext;
    end
  end

  // Defaults hold everything, which is exactly the stall behaviour
  always_comb begin
    stateNext  = state;
    holdOpNext = holdOp;
    holdPcNext = holdPc;
    validNext  = out_valid;
    instrNext  = out_instr;
    immNext    = out_imm;
    pcNext     = out_pc;
    hasImmNext = out_has_imm;

    if (flush) begin
      stateNext  = S_OP;
      holdOpNext = NOP_WORD;
      holdPcNext = '0;
      validNext  = 1'b0;
      instrNext  = NOP_WORD;
      immNext    = NOP_WORD;
      pcNext     = '0;
      hasImmNext = 1'b0;
    end else if (!stall) begin
      validNext  = 1'b0;
      instrNext  = NOP_WORD;
      immNext    = NOP_WORD;
      pcNext     = '0;
      hasImmNext = 1'b0;
      if (in_valid) begin
        unique case (state)
          S_OP: begin
            if (wordHasImm) begin
              holdOpNext = in_word;
              holdPcNext = in_pc;
              stateNext  = S_IMM;
            end else begin
              validNext = 1'b1;
              instrNext = in_word;
              pcNext    = in_pc;
            end
          end
          S_IMM: begin
            // Second word is data, so its flag bit is deliberately not examined
            validNext  = 1'b1;
            instrNext  = holdOp;
            immNext    = in_word;
            pcNext     = holdPc;
            hasImmNext = 1'b1;
            stateNext  = S_OP;
          end
          default: stateNext = S_OP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_id_assembler.sv
// tb/tb_if_id_assembler.sv - scoreboard bench for if_id_assembler with directed and random traffic
module tb_if_id_assembler;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush;
  logic [15:0] in_word;
  logic [31:0] in_pc;
  logic        fetch_hold, out_valid, out_has_imm;
  logic [15:0] out_instr, out_imm;
  logic [31:0] out_pc;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        hasImm;
  } rec_t;

  rec_t sbq[$];
  rec_t lastRec;
  bit   haveLast = 0;
  int   nChecks = 0;
  int   nErr = 0;

  // Reference model: at most one half-assembled instruction outstanding
  bit          partial = 0;
  logic [15:0] partOp;
  logic [31:0] partPc;

  if_id_assembler dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_word     (in_word),
    .in_pc       (in_pc),
    .stall       (stall),
    .flush       (flush),
    .fetch_hold  (fetch_hold),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_imm     (out_imm),
    .out_pc      (out_pc),
    .out_has_imm (out_has_imm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmpRec(input string tag, input rec_t e);
    chk({tag, ".instr"},  {16'h0, out_instr}, {16'h0, e.instr});
    chk({tag, ".imm"},    {16'h0, out_imm},   {16'h0, e.imm});
    chk({tag, ".pc"},     out_pc,             e.pc);
    chk({tag, ".hasImm"}, {31'h0, out_has_imm}, {31'h0, e.hasImm});
  endtask

  // One clock of stimulus; model decides what instruction, if any, completes at this edge
  task automatic step(input bit r, input bit v, input logic [15:0] w, input logic [31:0] pc,
                      input bit st, input bit fl);
    rec_t e;
    rst = r; in_valid = v; in_word = w; in_pc = pc; stall = st; flush = fl;
    #1;
    chk("fetch_hold", {31'h0, fetch_hold}, {31'h0, (st && !fl)});
    if (r || fl) begin
      partial = 0;
    end else if (!st && v) begin
      if (partial) begin
        e.instr = partOp; e.imm = w; e.pc = partPc; e.hasImm = 1;
        sbq.push_back(e);
        partial = 0;
      end else if (w[0]) begin
        partial = 1; partOp = w; partPc = pc;
      end else begin
        e.instr = w; e.imm = 16'h0000; e.pc = pc; e.hasImm = 0;
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: a valid slot after a non-stalled edge is a new instruction; after a stall it must repeat
  bit heldEdge = 0;
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (heldEdge) begin
        if (haveLast) cmpRec("held", lastRec);
      end else if (sbq.size() == 0) begin
        nChecks++; nErr++;
        $display("FAIL spurious_output: got instr %h pc %h expected no instruction", out_instr, out_pc);
      end else begin
        lastRec = sbq.pop_front();
        haveLast = 1;
        cmpRec("sb", lastRec);
      end
    end
    heldEdge = stall && !flush && !rst;
  end

  initial begin
    rst = 1; in_valid = 0; in_word = 0; in_pc = 0; stall = 0; flush = 0;
    @(posedge clk); #1;

    // 1: reset asserted while an opcode waits for its immediate
    step(0, 0, 16'h0, 0, 0, 0);
    step(0, 1, 16'h4401, 8, 0, 0);
    step(1, 1, 16'h1230, 9, 0, 0);
    step(1, 1, 16'h1230, 9, 1, 1);
    chk("rst.valid", {31'h0, out_valid}, 0);
    chk("rst.instr", {16'h0, out_instr}, 0);
    chk("rst.imm",   {16'h0, out_imm},   0);
    chk("rst.pc",    out_pc, 0);

    // 2: single word
    step(0, 1, 16'h1230, 5, 0, 0);
    chk("single.valid", {31'h0, out_valid}, 1);
    chk("single.instr", {16'h0, out_instr}, 32'h1230);
    chk("single.has",   {31'h0, out_has_imm}, 0);

    // 4: stall holds the slot while fetch data churns
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 16'($urandom), $urandom, 1, 0);
      chk("stall.instr", {16'h0, out_instr}, 32'h1230);
      chk("stall.pc",    out_pc, 5);
    end
    step(0, 1, 16'h2220, 6, 0, 0);
    chk("unstall.instr", {16'h0, out_instr}, 32'h2220);

    // 3: two-word instruction
    step(0, 1, 16'h4401, 8, 0, 0);
    chk("pair.bubble", {31'h0, out_valid}, 0);
    step(0, 1, 16'hBEEF, 9, 0, 0);
    chk("pair.instr", {16'h0, out_instr}, 32'h4401);
    chk("pair.imm",   {16'h0, out_imm},   32'hBEEF);
    chk("pair.pc",    out_pc, 8);

    // 5: flush drops the partial instruction and the same-cycle word
    step(0, 1, 16'h4401, 8, 0, 0);
    step(0, 1, 16'hBEEF, 9, 0, 1);
    chk("flush.valid", {31'h0, out_valid}, 0);
    step(0, 1, 16'h2000, 20, 0, 0);
    chk("flush.next", {16'h0, out_instr}, 32'h2000);
    chk("flush.has",  {31'h0, out_has_imm}, 0);

    // 6: flush+stall, then a fetch gap inside a pair
    step(0, 1, 16'h4401, 30, 0, 0);
    step(0, 1, 16'h5555, 31, 1, 1);
    chk("fs.valid", {31'h0, out_valid}, 0);
    step(0, 1, 16'h4403, 40, 0, 0);
    step(0, 0, 16'h7777, 99, 0, 0);
    chk("gap.bubble", {31'h0, out_valid}, 0);
    step(0, 1, 16'hABCD, 41, 0, 0);
    chk("gap.instr", {16'h0, out_instr}, 32'h4403);
    chk("gap.imm",   {16'h0, out_imm},   32'hABCD);
    chk("gap.pc",    out_pc, 40);

    // Randomized traffic, including back-to-back pairs
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(3) != 0), 16'($urandom), $urandom,
           ($urandom_range(6) == 0), ($urandom_range(19) == 0));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 0, 0, 0);
    chk("sb.drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErr);
    $finish;
  end

endmodule
